// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD window controller: command codes, view modes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package lcd_ctrl_pkg;

   localparam logic [3:0] CMD_LOAD     = 4'd0;
   localparam logic [3:0] CMD_ZOOM_IN  = 4'd1;
   localparam logic [3:0] CMD_ZOOM_FIT = 4'd2;
   localparam logic [3:0] CMD_RIGHT    = 4'd3;
   localparam logic [3:0] CMD_LEFT     = 4'd4;
   localparam logic [3:0] CMD_UP       = 4'd5;
   localparam logic [3:0] CMD_DOWN     = 4'd6;
   localparam logic [3:0] CMD_REFRESH  = 4'd7;
   localparam logic [3:0] CMD_MIRROR_H = 4'd8;
   localparam logic [3:0] CMD_MIRROR_V = 4'd9;

   typedef enum logic {FIT, ZOOM} mode_t;

   typedef enum logic [1:0] {IDLE, LOAD, EXEC, OUT} state_t;

endpackage

// File: rtl/lcd_addr_gen.sv
// Maps a window beat (r,c) to a frame-buffer address for the current view mode and mirroring.
// Latency: purely combinational.
// Backpressure: none; the address follows its inputs.
module lcd_addr_gen
   import lcd_ctrl_pkg::*;
#(
   parameter int IMG_W = 12,
   parameter int IMG_H = 9,
   parameter int WIN   = 4
) (
   input  mode_t                           mode,
   input  logic [$clog2(IMG_W)-1:0]        cx,
   input  logic [$clog2(IMG_H)-1:0]        cy,
   input  logic [$clog2(WIN)-1:0]          r,
   input  logic [$clog2(WIN)-1:0]          c,
   input  logic                            mir_h,
   input  logic                            mir_v,
   output logic [$clog2(IMG_W*IMG_H)-1:0]  addr
);

   localparam int AW     = $clog2(IMG_W*IMG_H);
   localparam int STEP_Y = IMG_H / WIN;
   localparam int STEP_X = IMG_W / WIN;

   int rr;
   int cc;
   int row;
   int col;

   // Reverse the beat coordinates when mirrored, then place the window in the image.
   always_comb begin
      rr  = mir_v ? (WIN - 1 - int'(r)) : int'(r);
      cc  = mir_h ? (WIN - 1 - int'(c)) : int'(c);
      row = rr * STEP_Y + STEP_Y / 2;
      col = cc * STEP_X + STEP_X / 2;
      if (mode == ZOOM) begin
         row = int'(cy) - WIN / 2 + rr;
         col = int'(cx) - WIN / 2 + cc;
      end
      addr = AW'(row * IMG_W + col);
   end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// Frame-buffered LCD controller: Load a frame, then serve a WIN x WIN fit/zoom window; mirroring under LCD_CTRL_MIRROR_EN.
// Latency: Load = IMG_W*IMG_H cycles + WIN*WIN beats; other commands = 1 exec cycle + WIN*WIN beats.
// Backpressure: busy is high while a command runs and cmd_valid is ignored until it drops.
module lcd_ctrl_gen
   import lcd_ctrl_pkg::*;
#(
   parameter int DW    = 8,
   parameter int IMG_W = 12,
   parameter int IMG_H = 9,
   parameter int WIN   = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] datain,
   input  logic [3:0]    cmd,
   input  logic          cmd_valid,
   output logic [DW-1:0] dataout,
   output logic          output_valid,
   output logic          busy
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int AW   = $clog2(NPIX);
   localparam int XW   = $clog2(IMG_W);
   localparam int YW   = $clog2(IMG_H);
   localparam int RW   = $clog2(WIN);

   localparam logic [XW-1:0] CX_RST = XW'(IMG_W / 2);
   localparam logic [XW-1:0] CX_MIN = XW'(WIN / 2);
   localparam logic [XW-1:0] CX_MAX = XW'(IMG_W - WIN / 2);
   localparam logic [YW-1:0] CY_RST = YW'((IMG_H + 1) / 2);
   localparam logic [YW-1:0] CY_MIN = YW'(WIN / 2);
   localparam logic [YW-1:0] CY_MAX = YW'(IMG_H - WIN / 2);
   localparam logic [RW-1:0] RC_MAX = RW'(WIN - 1);
   localparam logic [AW-1:0] LD_MAX = AW'(NPIX - 1);

   state_t        state;
   mode_t         mode;
   logic [3:0]    cmd_q;
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic [AW-1:0] load_cnt;
   logic [RW-1:0] r;
   logic [RW-1:0] c;
   logic [AW-1:0] rd_addr;
   logic          mir_h;
   logic          mir_v;
   logic [DW-1:0] mem [NPIX];

`ifndef LCD_CTRL_MIRROR_EN
   assign mir_h = 1'b0;
   assign mir_v = 1'b0;
`endif

   lcd_addr_gen #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .WIN   (WIN)
   ) u_addr_gen (
      .mode  (mode),
      .cx    (cx),
      .cy    (cy),
      .r     (r),
      .c     (c),
      .mir_h (mir_h),
      .mir_v (mir_v),
      .addr  (rd_addr)
   );

   // Frame buffer: one raster-order pixel written per Load cycle; contents survive reset.
   always_ff @(posedge clk) begin
      if (state == LOAD) begin
         mem[load_cnt] <= datain;
      end
   end

   // Command FSM: accept in IDLE, stream pixels in LOAD, update view in EXEC, emit window in OUT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         mode         <= FIT;
         cmd_q        <= CMD_REFRESH;
         cx           <= CX_RST;
         cy           <= CY_RST;
         load_cnt     <= '0;
         r            <= '0;
         c            <= '0;
         busy         <= 1'b0;
         output_valid <= 1'b0;
         dataout      <= '0;
`ifdef LCD_CTRL_MIRROR_EN
         mir_h        <= 1'b0;
         mir_v        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               output_valid <= 1'b0;
               if (cmd_valid) begin
                  cmd_q    <= cmd;
                  busy     <= 1'b1;
                  load_cnt <= '0;
                  r        <= '0;
                  c        <= '0;
                  state    <= (cmd == CMD_LOAD) ? LOAD : EXEC;
               end
            end
            LOAD: begin
               if (load_cnt == LD_MAX) begin
                  mode  <= FIT;
                  state <= OUT;
`ifdef LCD_CTRL_MIRROR_EN
                  mir_h <= 1'b0;
                  mir_v <= 1'b0;
`endif
               end else begin
                  load_cnt <= load_cnt + AW'(1);
               end
            end
            EXEC: begin
               case (cmd_q)
                  CMD_ZOOM_IN: begin
                     if (mode == FIT) begin
                        mode <= ZOOM;
                        cx   <= CX_RST;
                        cy   <= CY_RST;
                     end
                  end
                  CMD_ZOOM_FIT: mode <= FIT;
                  CMD_RIGHT: if (mode == ZOOM && cx < CX_MAX) cx <= cx + XW'(1);
                  CMD_LEFT:  if (mode == ZOOM && cx > CX_MIN) cx <= cx - XW'(1);
                  CMD_UP:    if (mode == ZOOM && cy > CY_MIN) cy <= cy - YW'(1);
                  CMD_DOWN:  if (mode == ZOOM && cy < CY_MAX) cy <= cy + YW'(1);
`ifdef LCD_CTRL_MIRROR_EN
                  CMD_MIRROR_H: mir_h <= ~mir_h;
                  CMD_MIRROR_V: mir_v <= ~mir_v;
`endif
                  default: ;
               endcase
               state <= OUT;
            end
            OUT: begin
               dataout      <= mem[rd_addr];
               output_valid <= 1'b1;
               if (c == RC_MAX) begin
                  c <= '0;
                  if (r == RC_MAX) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     r <= r + RW'(1);
                  end
               end else begin
                  c <= c + RW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Scoreboard bench for lcd_ctrl_gen: a window-level model queues expected beats, a monitor compares them.
// Latency: n/a (testbench).
// Backpressure: waits on busy before each command, every wait bounded.
`timescale 1ns/1ps
module tb_lcd_ctrl_gen;

   localparam int DW    = 8;
   localparam int IMG_W = 12;
   localparam int IMG_H = 9;
   localparam int WIN   = 4;
   localparam int NPIX  = IMG_W * IMG_H;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] datain;
   logic [3:0]    cmd;
   logic          cmd_valid;
   logic [DW-1:0] dataout;
   logic          output_valid;
   logic          busy;

   always #5 clk = ~clk;

   lcd_ctrl_gen #(
      .DW    (DW),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .WIN   (WIN)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .datain       (datain),
      .cmd          (cmd),
      .cmd_valid    (cmd_valid),
      .dataout      (dataout),
      .output_valid (output_valid),
      .busy         (busy)
   );

   typedef struct {
      logic [DW-1:0] data;
      bit            last;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   // Reference model: image contents plus view state, as the command rules describe them.
   int img[NPIX];
   int load_pix[NPIX];
   bit m_zoom;
   int m_cx, m_cy;
   bit m_mh, m_mv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_reset();
      m_zoom = 1'b0;
      m_cx   = IMG_W / 2;
      m_cy   = (IMG_H + 1) / 2;
      m_mh   = 1'b0;
      m_mv   = 1'b0;
   endfunction

   function automatic void model_cmd(input int c);
      case (c)
         0: begin
            for (int i = 0; i < NPIX; i++) img[i] = load_pix[i];
            m_zoom = 1'b0;
            m_mh   = 1'b0;
            m_mv   = 1'b0;
         end
         1: if (!m_zoom) begin
            m_zoom = 1'b1;
            m_cx   = IMG_W / 2;
            m_cy   = (IMG_H + 1) / 2;
         end
         2: m_zoom = 1'b0;
         3: if (m_zoom && m_cx < IMG_W - WIN / 2) m_cx++;
         4: if (m_zoom && m_cx > WIN / 2) m_cx--;
         5: if (m_zoom && m_cy > WIN / 2) m_cy--;
         6: if (m_zoom && m_cy < IMG_H - WIN / 2) m_cy++;
`ifdef LCD_CTRL_MIRROR_EN
         8: m_mh = !m_mh;
         9: m_mv = !m_mv;
`endif
         default: ;
      endcase
   endfunction

   function automatic void push_window();
      beat_t b;
      int rr, cc, row, col;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN; c++) begin
            rr = m_mv ? WIN - 1 - r : r;
            cc = m_mh ? WIN - 1 - c : c;
            if (m_zoom) begin
               row = m_cy - WIN / 2 + rr;
               col = m_cx - WIN / 2 + cc;
            end else begin
               row = rr * (IMG_H / WIN) + (IMG_H / WIN) / 2;
               col = cc * (IMG_W / WIN) + (IMG_W / WIN) / 2;
            end
            b.data = DW'(img[row * IMG_W + col]);
            b.last = (r == WIN - 1) && (c == WIN - 1);
            exp_q.push_back(b);
         end
      end
   endfunction

   // Issue one command, stream a frame for Load, optionally poke cmd_valid mid-output, then wait for completion.
   task automatic do_cmd(input int c, input bit pulse_mid);
      int t;
      model_cmd(c);
      push_window();
      cmd       = 4'(c);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = 4'($urandom);
      check("accept_busy", {31'd0, busy}, 32'd1);
      if (c == 0) begin
         for (int i = 0; i < NPIX; i++) begin
            datain = DW'(load_pix[i]);
            @(negedge clk);
         end
      end
      if (pulse_mid) begin
         repeat (6) @(negedge clk);
         cmd       = 4'd1;
         cmd_valid = 1'b1;
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      t = 0;
      while (busy === 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("cmd_done_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("valid_after_last", {31'd0, output_valid}, 32'd0);
      check("queue_drained", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int c;
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd       = 4'd0;
      datain    = '0;
      model_reset();

      // Monitor: every presented beat must match the head of the expected queue.
      fork
         forever begin
            @(negedge clk);
            if (reset === 1'b1 && output_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", {24'd0, dataout}, 32'hFFFF_FFFF);
               end else begin
                  beat_t e;
                  e = exp_q.pop_front();
                  check("beat_data", {24'd0, dataout}, {24'd0, e.data});
                  check("beat_busy", {31'd0, busy}, e.last ? 32'd0 : 32'd1);
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_valid", {31'd0, output_valid}, 32'd0);
      check("reset_dataout", {24'd0, dataout}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Directed: ramp image, fit/zoom views, saturation, fit-mode shift ignore, mirrors, unknown codes.
      for (int i = 0; i < NPIX; i++) load_pix[i] = i;
      do_cmd(0, 1'b0);
      do_cmd(7, 1'b0);
      do_cmd(1, 1'b0);
      repeat (5) do_cmd(3, 1'b0);
      repeat (4) do_cmd(5, 1'b0);
      do_cmd(2, 1'b0);
      repeat (3) do_cmd(3, 1'b0);
      do_cmd(7, 1'b0);
      do_cmd(1, 1'b0);
      do_cmd(8, 1'b0);
      do_cmd(9, 1'b0);
      do_cmd(12, 1'b0);
      do_cmd(6, 1'b0);
      do_cmd(4, 1'b0);
      do_cmd(2, 1'b0);
      do_cmd(8, 1'b0);
      do_cmd(7, 1'b1);

      // Reset in the middle of a Load must abort it at once.
      for (int i = 0; i < NPIX; i++) load_pix[i] = int'($urandom_range(0, 255));
      cmd       = 4'd0;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (40) begin
         datain = DW'($urandom);
         @(negedge clk);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("midload_reset_busy", {31'd0, busy}, 32'd0);
      check("midload_reset_valid", {31'd0, output_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      exp_q.delete();
      @(negedge clk);
      do_cmd(0, 1'b0);
      do_cmd(1, 1'b0);

      // Random command stream with occasional fresh random frames.
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            for (int i = 0; i < NPIX; i++) load_pix[i] = int'($urandom_range(0, 255));
            c = 0;
         end else begin
            c = int'($urandom_range(1, 15));
         end
         do_cmd(c, ($urandom_range(0, 7) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
